// File: rtl/tank_layer_mapper.sv
// Three-stage pixel colour mapper: rotated square tank bodies over grey, with frame-synchronous shadow parameters.
// Define TANK_LAYER_BARREL_EN to also draw a barrel ahead of each body at half brightness.
module tank_layer_mapper #(
    parameter int NUM_TANKS     = 2,
    parameter int COORD_W       = 10,
    parameter int TRIG_W        = 8,
    parameter int HALF_SIZE     = 8,
    parameter int BARREL_LEN    = 6,
    parameter int BARREL_HALF_W = 1
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          frame_start,
    input  logic [NUM_TANKS-1:0]          tank_en,
    input  logic [NUM_TANKS*COORD_W-1:0]  tank_x,
    input  logic [NUM_TANKS*COORD_W-1:0]  tank_y,
    input  logic [NUM_TANKS*TRIG_W-1:0]   tank_sin,
    input  logic [NUM_TANKS*TRIG_W-1:0]   tank_cos,
    input  logic [NUM_TANKS*24-1:0]       tank_rgb,
    input  logic                          pix_valid,
    input  logic [COORD_W-1:0]            DrawX,
    input  logic [COORD_W-1:0]            DrawY,
    input  logic                          blank,
    output logic                          out_valid,
    output logic [7:0]                    Red,
    output logic [7:0]                    Green,
    output logic [7:0]                    Blue
);

    localparam int PROD_W = COORD_W + TRIG_W + 1;
    localparam int SUM_W  = PROD_W + 1;
    localparam int SHIFT  = TRIG_W - 2;

    localparam logic signed [SUM_W-1:0] HS_POS = SUM_W'(HALF_SIZE);
    localparam logic signed [SUM_W-1:0] HS_NEG = -HS_POS;
    localparam logic signed [SUM_W-1:0] BL_MAX = SUM_W'(HALF_SIZE + BARREL_LEN);
    localparam logic signed [SUM_W-1:0] BW_POS = SUM_W'(BARREL_HALF_W);
    localparam logic signed [SUM_W-1:0] BW_NEG = -BW_POS;

    // A constant-false enable lets elaboration strip the barrel comparators entirely.
`ifdef TANK_LAYER_BARREL_EN
    localparam bit BARREL_ON = 1'b1;
`else
    localparam bit BARREL_ON = 1'b0;
`endif

    function automatic logic signed [PROD_W-1:0] mul_ext(input logic signed [COORD_W:0]   d,
                                                         input logic signed [TRIG_W-1:0] t);
        logic signed [PROD_W-1:0] de;
        logic signed [PROD_W-1:0] te;
        de = {{TRIG_W{d[COORD_W]}}, d};
        te = {{(COORD_W+1){t[TRIG_W-1]}}, t};
        return de * te;
    endfunction

    function automatic logic signed [SUM_W-1:0] add_ext(input logic signed [PROD_W-1:0] a,
                                                        input logic signed [PROD_W-1:0] b,
                                                        input logic                     sub);
        logic signed [SUM_W-1:0] ae;
        logic signed [SUM_W-1:0] be;
        ae = {a[PROD_W-1], a};
        be = {b[PROD_W-1], b};
        return sub ? (ae - be) : (ae + be);
    endfunction

    logic [NUM_TANKS-1:0]        sh_en;
    logic [COORD_W-1:0]          sh_x   [NUM_TANKS];
    logic [COORD_W-1:0]          sh_y   [NUM_TANKS];
    logic signed [TRIG_W-1:0]    sh_sin [NUM_TANKS];
    logic signed [TRIG_W-1:0]    sh_cos [NUM_TANKS];
    logic [23:0]                 sh_rgb [NUM_TANKS];

    logic                        s1_valid, s1_blank;
    logic [NUM_TANKS-1:0]        s1_en;
    logic signed [COORD_W:0]     s1_dx  [NUM_TANKS];
    logic signed [COORD_W:0]     s1_dy  [NUM_TANKS];
    logic signed [TRIG_W-1:0]    s1_sin [NUM_TANKS];
    logic signed [TRIG_W-1:0]    s1_cos [NUM_TANKS];
    logic [23:0]                 s1_rgb [NUM_TANKS];

    logic                        s2_valid, s2_blank;
    logic [NUM_TANKS-1:0]        s2_en;
    logic signed [SUM_W-1:0]     s2_u   [NUM_TANKS];
    logic signed [SUM_W-1:0]     s2_v   [NUM_TANKS];
    logic [23:0]                 s2_rgb [NUM_TANKS];

    logic signed [SUM_W-1:0]     u_c    [NUM_TANKS];
    logic signed [SUM_W-1:0]     v_c    [NUM_TANKS];
    logic [NUM_TANKS-1:0]        body_hit, barrel_hit;
    logic [23:0]                 hit_rgb;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sh_en <= '0;
            for (int i = 0; i < NUM_TANKS; i++) begin
                sh_x[i]   <= '0;
                sh_y[i]   <= '0;
                sh_sin[i] <= '0;
                sh_cos[i] <= '0;
                sh_rgb[i] <= '0;
            end
        end else if (frame_start) begin
            sh_en <= tank_en;
            for (int i = 0; i < NUM_TANKS; i++) begin
                sh_x[i]   <= tank_x[i*COORD_W +: COORD_W];
                sh_y[i]   <= tank_y[i*COORD_W +: COORD_W];
                sh_sin[i] <= tank_sin[i*TRIG_W +: TRIG_W];
                sh_cos[i] <= tank_cos[i*TRIG_W +: TRIG_W];
                sh_rgb[i] <= tank_rgb[i*24 +: 24];
            end
        end
    end

    // Heading and colour travel with the pixel so a mid-frame latch never mixes two frames' parameters.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1_valid <= 1'b0;
            s1_blank <= 1'b0;
            s1_en    <= '0;
            for (int i = 0; i < NUM_TANKS; i++) begin
                s1_dx[i]  <= '0;
                s1_dy[i]  <= '0;
                s1_sin[i] <= '0;
                s1_cos[i] <= '0;
                s1_rgb[i] <= '0;
            end
        end else begin
            s1_valid <= pix_valid;
            s1_blank <= blank;
            s1_en    <= sh_en;
            for (int i = 0; i < NUM_TANKS; i++) begin
                s1_dx[i]  <= $signed({1'b0, DrawX}) - $signed({1'b0, sh_x[i]});
                s1_dy[i]  <= $signed({1'b0, DrawY}) - $signed({1'b0, sh_y[i]});
                s1_sin[i] <= sh_sin[i];
                s1_cos[i] <= sh_cos[i];
                s1_rgb[i] <= sh_rgb[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_TANKS; i++) begin
            u_c[i] = add_ext(mul_ext(s1_dx[i], s1_cos[i]), mul_ext(s1_dy[i], s1_sin[i]), 1'b0) >>> SHIFT;
            v_c[i] = add_ext(mul_ext(s1_dy[i], s1_cos[i]), mul_ext(s1_dx[i], s1_sin[i]), 1'b1) >>> SHIFT;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s2_valid <= 1'b0;
            s2_blank <= 1'b0;
            s2_en    <= '0;
            for (int i = 0; i < NUM_TANKS; i++) begin
                s2_u[i]   <= '0;
                s2_v[i]   <= '0;
                s2_rgb[i] <= '0;
            end
        end else begin
            s2_valid <= s1_valid;
            s2_blank <= s1_blank;
            s2_en    <= s1_en;
            for (int i = 0; i < NUM_TANKS; i++) begin
                s2_u[i]   <= u_c[i];
                s2_v[i]   <= v_c[i];
                s2_rgb[i] <= s1_rgb[i];
            end
        end
    end

    // NOTE: every combinational output gets a default before the loop, so no latch can be inferred.
    always_comb begin
        body_hit   = '0;
        barrel_hit = '0;
        hit_rgb    = 24'h555555;
        for (int i = 0; i < NUM_TANKS; i++) begin
            body_hit[i]   = s2_en[i] && (s2_u[i] >= HS_NEG) && (s2_u[i] <= HS_POS)
                                     && (s2_v[i] >= HS_NEG) && (s2_v[i] <= HS_POS);
            barrel_hit[i] = BARREL_ON && s2_en[i] && (s2_u[i] > HS_POS) && (s2_u[i] <= BL_MAX)
                                      && (s2_v[i] >= BW_NEG) && (s2_v[i] <= BW_POS);
        end
        // Walk from the highest index down so the lowest-index hit is written last and wins.
        for (int i = NUM_TANKS - 1; i >= 0; i--) begin
            if (body_hit[i])
                hit_rgb = s2_rgb[i];
            else if (barrel_hit[i])
                hit_rgb = {1'b0, s2_rgb[i][23:17], 1'b0, s2_rgb[i][15:9], 1'b0, s2_rgb[i][7:1]};
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            out_valid           <= 1'b0;
            {Red, Green, Blue}  <= 24'h000000;
        end else begin
            out_valid           <= s2_valid;
            {Red, Green, Blue}  <= (s2_valid && s2_blank) ? hit_rgb : 24'h000000;
        end
    end

endmodule

// File: tb/tb_tank_layer_mapper.sv
// Self-checking bench for tank_layer_mapper: directed scenarios plus randomized pixels against a frame-level colour model.
module tb_tank_layer_mapper;

    localparam int N   = 2;
    localparam int CW  = 10;
    localparam int TW  = 8;
    localparam int HS  = 8;
    localparam int BL  = 6;
    localparam int BHW = 1;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              frame_start;
    logic [N-1:0]      tank_en;
    logic [N*CW-1:0]   tank_x, tank_y;
    logic [N*TW-1:0]   tank_sin, tank_cos;
    logic [N*24-1:0]   tank_rgb;
    logic              pix_valid;
    logic [CW-1:0]     DrawX, DrawY;
    logic              blank;
    logic              out_valid;
    logic [7:0]        Red, Green, Blue;

    tank_layer_mapper #(
        .NUM_TANKS(N), .COORD_W(CW), .TRIG_W(TW),
        .HALF_SIZE(HS), .BARREL_LEN(BL), .BARREL_HALF_W(BHW)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
        .tank_en(tank_en), .tank_x(tank_x), .tank_y(tank_y),
        .tank_sin(tank_sin), .tank_cos(tank_cos), .tank_rgb(tank_rgb),
        .pix_valid(pix_valid), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .out_valid(out_valid), .Red(Red), .Green(Green), .Blue(Blue)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Reference state: what the design should have latched at the last frame_start.
    bit          m_en  [N];
    int          m_x   [N];
    int          m_y   [N];
    int          m_s   [N];
    int          m_c   [N];
    logic [23:0] m_rgb [N];

    // Expected {valid, rgb} per pixel, oldest first; holds the two pipeline slots ahead of the output.
    logic [24:0] exp_q [$];

    task automatic check(input string tag, input logic [24:0] got, input logic [24:0] expd);
        checks++;
        assert (got === expd) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, expd);
        end
    endtask

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    function automatic logic [23:0] model_rgb(input int px, input int py);
        int dx, dy, u, v;
        logic [7:0] r, g, b;
        for (int i = 0; i < N; i++) begin
            if (!m_en[i]) continue;
            dx = px - m_x[i];
            dy = py - m_y[i];
            u  = (dx * m_c[i] + dy * m_s[i]) >>> (TW - 2);
            v  = (dy * m_c[i] - dx * m_s[i]) >>> (TW - 2);
            if (iabs(u) <= HS && iabs(v) <= HS) return m_rgb[i];
`ifdef TANK_LAYER_BARREL_EN
            if (u > HS && u <= HS + BL && iabs(v) <= BHW) begin
                r = m_rgb[i][23:16] / 2;
                g = m_rgb[i][15:8] / 2;
                b = m_rgb[i][7:0] / 2;
                return {r, g, b};
            end
`endif
        end
        return 24'h555555;
    endfunction

    task automatic latch_model();
        for (int i = 0; i < N; i++) begin
            m_en[i]  = tank_en[i];
            m_x[i]   = int'(tank_x[i*CW +: CW]);
            m_y[i]   = int'(tank_y[i*CW +: CW]);
            m_s[i]   = int'($signed(tank_sin[i*TW +: TW]));
            m_c[i]   = int'($signed(tank_cos[i*TW +: TW]));
            m_rgb[i] = tank_rgb[i*24 +: 24];
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            m_en[i] = 1'b0; m_x[i] = 0; m_y[i] = 0; m_s[i] = 0; m_c[i] = 0; m_rgb[i] = 24'h0;
        end
        exp_q = '{25'h0, 25'h0};
    endtask

    task automatic set_tank(input int i, input bit en, input int x, input int y,
                            input int s, input int c, input logic [23:0] rgb);
        tank_en[i]             = en;
        tank_x[i*CW +: CW]     = CW'(x);
        tank_y[i*CW +: CW]     = CW'(y);
        tank_sin[i*TW +: TW]   = TW'(s);
        tank_cos[i*TW +: TW]   = TW'(c);
        tank_rgb[i*24 +: 24]   = rgb;
    endtask

    // One clock of stimulus: expected colour is fixed from the shadows in force at this edge.
    task automatic step(input bit pv, input int px, input int py, input bit vis, input bit fs, input string tag);
        logic [24:0] e;
        pix_valid   = pv;
        DrawX       = CW'(px);
        DrawY       = CW'(py);
        blank       = vis;
        frame_start = fs;
        e = pv ? {1'b1, (vis ? model_rgb(px, py) : 24'h000000)} : 25'h0;
        exp_q.push_back(e);
        if (fs) latch_model();
        @(posedge Clk);
        #1;
        check(tag, {out_valid, Red, Green, Blue}, exp_q.pop_front());
    endtask

    initial begin
        frame_start = 1'b0; pix_valid = 1'b0; blank = 1'b1;
        DrawX = '0; DrawY = '0;
        tank_en = '0; tank_x = '0; tank_y = '0;
        tank_sin = '0; tank_cos = '0; tank_rgb = '0;
        repeat (2) @(posedge Clk);
        #1;
        check("reset_out", {out_valid, Red, Green, Blue}, 25'h0);
        Reset = 1'b0;
        clear_model();

        // Heading 0: body edge, barrel position, background
        set_tank(0, 1'b1, 320, 240, 0, 64, 24'hFFBB00);
        set_tank(1, 1'b0, 0, 0, 0, 64, 24'h0000FF);
        step(1'b1, 328, 240, 1'b1, 1'b1, "pre_latch_pixel");
        step(1'b1, 328, 240, 1'b1, 1'b0, "h0_body_edge");
        step(1'b1, 329, 240, 1'b1, 1'b0, "h0_barrel_pos");
        step(1'b1, 336, 240, 1'b1, 1'b0, "h0_background");
        step(1'b0, 320, 240, 1'b1, 1'b0, "idle_bubble");

        // Heading 90 degrees
        set_tank(0, 1'b1, 320, 240, 64, 0, 24'hFFBB00);
        step(1'b0, 0, 0, 1'b1, 1'b1, "h90_latch");
        step(1'b1, 320, 248, 1'b1, 1'b0, "h90_body");
        step(1'b1, 320, 250, 1'b1, 1'b0, "h90_barrel_pos");
        step(1'b1, 329, 240, 1'b1, 1'b0, "h90_background");

        // Overlap priority
        set_tank(0, 1'b1, 100, 100, 0, 64, 24'hFF0000);
        set_tank(1, 1'b1, 100, 100, 0, 64, 24'h00FF00);
        step(1'b0, 0, 0, 1'b1, 1'b1, "prio_latch");
        step(1'b1, 100, 100, 1'b1, 1'b0, "prio_tank0");
        set_tank(0, 1'b0, 100, 100, 0, 64, 24'hFF0000);
        step(1'b1, 100, 100, 1'b1, 1'b1, "prio_latch_old");
        step(1'b1, 100, 100, 1'b1, 1'b0, "prio_tank1");

        // Parameter change without and with frame_start
        set_tank(1, 1'b1, 200, 100, 0, 64, 24'h00FF00);
        step(1'b1, 100, 100, 1'b1, 1'b0, "no_latch_hold");
        step(1'b1, 100, 100, 1'b1, 1'b1, "coincident_old");
        step(1'b1, 100, 100, 1'b1, 1'b0, "coincident_new");
        step(1'b1, 200, 100, 1'b1, 1'b0, "moved_body");

        // Blanking inside a body, and a tank on the left edge
        step(1'b1, 200, 100, 1'b0, 1'b0, "blank_in_body");
        set_tank(0, 1'b1, 0, 100, 0, 64, 24'h123456);
        step(1'b0, 0, 0, 1'b1, 1'b1, "edge_latch");
        step(1'b1, 0, 100, 1'b1, 1'b0, "edge_body");
        step(1'b1, 1023, 100, 1'b1, 1'b0, "edge_no_wrap");
        step(1'b1, 5, 100, 1'b1, 1'b0, "edge_body_right");

        // Reset mid-stream with pix_valid held high
        step(1'b1, 0, 100, 1'b1, 1'b0, "pre_reset");
        Reset = 1'b1;
        #1;
        check("reset_async", {out_valid, Red, Green, Blue}, 25'h0);
        @(posedge Clk);
        #1;
        check("reset_edge", {out_valid, Red, Green, Blue}, 25'h0);
        Reset = 1'b0;
        clear_model();
        step(1'b1, 0, 100, 1'b1, 1'b1, "post_rst_1");
        step(1'b1, 0, 100, 1'b1, 1'b0, "post_rst_2");
        step(1'b1, 1023, 100, 1'b1, 1'b0, "post_rst_3");
        step(1'b1, 0, 100, 1'b1, 1'b0, "post_rst_4");

        // Randomized frames with occasional coincident latches
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++)
                set_tank(i, $urandom_range(0, 3) != 0, int'($urandom_range(0, 1023)),
                         int'($urandom_range(0, 767)), int'($urandom_range(0, 128)) - 64,
                         int'($urandom_range(0, 128)) - 64, 24'($urandom()));
            step(1'b0, 0, 0, 1'b1, 1'b1, "rnd_latch");
            for (int k = 0; k < 40; k++) begin
                int t, px, py;
                bit fs;
                t  = int'($urandom_range(0, N - 1));
                px = (m_x[t] + int'($urandom_range(0, 40)) - 20) & 1023;
                py = (m_y[t] + int'($urandom_range(0, 40)) - 20) & 1023;
                fs = ($urandom_range(0, 11) == 0);
                if ($urandom_range(0, 7) == 0)
                    set_tank(t, 1'b1, int'($urandom_range(0, 1023)), int'($urandom_range(0, 767)),
                             int'($urandom_range(0, 128)) - 64, int'($urandom_range(0, 128)) - 64,
                             24'($urandom()));
                step($urandom_range(0, 4) != 0, px, py, $urandom_range(0, 9) != 0, fs, "rnd_pixel");
            end
        end

        step(1'b0, 0, 0, 1'b1, 1'b0, "drain_1");
        step(1'b0, 0, 0, 1'b1, 1'b0, "drain_2");
        step(1'b0, 0, 0, 1'b1, 1'b0, "drain_3");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
